tile_scheduler: RTL and testbench



---
 rtl/tile_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tile_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// Raster-order tile sequencer feeding the framebuffer streamer through a
// ping-pong pair of tile buffers, flipping the SRAM page on vertical sync.
module tile_scheduler #(
    parameter int tileDim      = 8,
    parameter int screenWidth  = 640,
    parameter int screenHeight = 480
) (
    input  logic       BOARD_CLK,
    input  logic       Reset,
    output logic       renderStart,
    output logic [9:0] renderX,
    output logic [9:0] renderY,
    output logic       renderTileID,
    input  logic       renderDone,
    output logic       streamTileTrigger,
    output logic [9:0] xOffset,
    output logic [9:0] yOffset,
    output logic       streamingTileID,
    output logic       nextStreamingTileID,
    input  logic       doneStreaming,
    input  logic       VGA_VS,
    output logic       doubleBuffer,
    output logic       frameDone
);

    localparam int TX    = screenWidth / tileDim;
    localparam int TY    = screenHeight / tileDim;
    localparam int TOTAL = TX * TY;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TXW   = (TX > 1) ? $clog2(TX) : 1;

    localparam logic [CW-1:0]  TOTAL_C = CW'(TOTAL);
    localparam logic [TXW-1:0] LAST_TX = TXW'(TX - 1);
    localparam logic [9:0]     STEP    = 10'(tileDim);

    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_END} renderState_t;
    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_RUN, S_FRAME} streamState_t;

    renderState_t     renderState;
    streamState_t     streamState;
    logic [1:0]       full;
    logic             renderBuf;
    logic             streamBuf;
    logic [1:0][9:0]  originX;
    logic [1:0][9:0]  originY;
    logic [TXW-1:0]   tileX;
    logic [9:0]       curX;
    logic [9:0]       curY;
    logic [CW-1:0]    renderCount;
    logic [CW-1:0]    streamCount;
    logic             vsSync;
    logic             vsPrev;

    assign nextStreamingTileID = streamingTileID;

    // Pixel origins are accumulated modulo 1024 so they stay truncated to
    // 10 bits, while tileX alone decides when a tile row wraps.
    always_ff @(posedge BOARD_CLK) begin
        if (Reset) begin
            renderState       <= R_IDLE;
            streamState       <= S_IDLE;
            full              <= '0;
            renderBuf         <= 1'b0;
            streamBuf         <= 1'b0;
            originX           <= '0;
            originY           <= '0;
            tileX             <= '0;
            curX              <= '0;
            curY              <= '0;
            renderCount       <= '0;
            streamCount       <= '0;
            vsSync            <= 1'b0;
            vsPrev            <= 1'b0;
            renderStart       <= 1'b0;
            renderX           <= '0;
            renderY           <= '0;
            renderTileID      <= 1'b0;
            streamTileTrigger <= 1'b0;
            xOffset           <= '0;
            yOffset           <= '0;
            streamingTileID   <= 1'b0;
            doubleBuffer      <= 1'b0;
            frameDone         <= 1'b0;
        end else begin
            renderStart <= 1'b0;
            frameDone   <= 1'b0;
            vsSync      <= VGA_VS;
            vsPrev      <= vsSync;

            case (renderState)
                R_IDLE: begin
                    if (renderCount != TOTAL_C && !full[renderBuf]) begin
                        renderStart  <= 1'b1;
                        renderX      <= curX;
                        renderY      <= curY;
                        renderTileID <= renderBuf;
                        renderCount  <= renderCount + 1'b1;
                        renderState  <= R_BUSY;
                        if (tileX == LAST_TX) begin
                            tileX <= '0;
                            curX  <= '0;
                            curY  <= curY + STEP;
                        end else begin
                            tileX <= tileX + 1'b1;
                            curX  <= curX + STEP;
                        end
                    end
                end
                R_BUSY: begin
                    if (renderDone) begin
                        full[renderBuf]    <= 1'b1;
                        originX[renderBuf] <= renderX;
                        originY[renderBuf] <= renderY;
                        renderBuf          <= ~renderBuf;
                        renderState        <= (renderCount == TOTAL_C) ? R_END : R_IDLE;
                    end
                end
                default: ;
            endcase

            // A release here and a renderDone above always touch different
            // bits of full, so both updates land in the same cycle.
            case (streamState)
                S_IDLE: begin
                    if (full[streamBuf] && doneStreaming) begin
                        xOffset           <= originX[streamBuf];
                        yOffset           <= originY[streamBuf];
                        streamingTileID   <= streamBuf;
                        streamTileTrigger <= 1'b1;
                        streamState       <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (!doneStreaming) begin
                        streamTileTrigger <= 1'b0;
                        streamState       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (doneStreaming) begin
                        full[streamBuf] <= 1'b0;
                        streamBuf       <= ~streamBuf;
                        streamCount     <= streamCount + 1'b1;
                        if (streamCount + 1'b1 == TOTAL_C) begin
                            frameDone   <= 1'b1;
                            streamState <= S_FRAME;
                        end else begin
                            streamState <= S_IDLE;
                        end
                    end
                end
                S_FRAME: begin
                    if (vsPrev && !vsSync) begin
                        doubleBuffer <= ~doubleBuffer;
                        tileX        <= '0;
                        curX         <= '0;
                        curY         <= '0;
                        renderCount  <= '0;
                        streamCount  <= '0;
                        renderBuf    <= 1'b0;
                        streamBuf    <= 1'b0;
                        renderState  <= R_IDLE;
                        streamState  <= S_IDLE;
                    end
                end
                default: streamState <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler on a 4x2-tile screen, with behavioural
// rasteriser and framebuffer models plus manually driven corner cases.
module tb_tile_scheduler;

    localparam int TILE    = 8;
    localparam int WIDTH   = 32;
    localparam int HEIGHT  = 16;
    localparam int TILES_X = WIDTH / TILE;
    localparam int TILES   = TILES_X * (HEIGHT / TILE);
    localparam int FB_BUSY = 70;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       id;
    } tileExp_t;

    logic       BOARD_CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       renderStart;
    logic [9:0] renderX;
    logic [9:0] renderY;
    logic       renderTileID;
    logic       renderDone;
    logic       streamTileTrigger;
    logic [9:0] xOffset;
    logic [9:0] yOffset;
    logic       streamingTileID;
    logic       nextStreamingTileID;
    logic       doneStreaming;
    logic       VGA_VS = 1'b1;
    logic       doubleBuffer;
    logic       frameDone;

    logic rastEnable = 1'b1;
    logic rastDone   = 1'b0;
    logic tbDone     = 1'b0;
    logic fbManual   = 1'b0;
    logic fbIdle     = 1'b1;
    logic tbIdle     = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int renderStarts = 0;
    int triggers = 0;
    int frameDones = 0;
    int startsBeforeRelease = 0;
    int thirdStart = 0;
    int firstRelease = 0;
    int trigWidth = 0;
    logic sawRelease = 1'b0;
    logic prevTrig = 1'b0;

    tileExp_t renderQ[$];
    tileExp_t streamQ[$];

    assign renderDone    = rastDone | tbDone;
    assign doneStreaming = fbManual ? tbIdle : fbIdle;

    always #5 BOARD_CLK = ~BOARD_CLK;

    tile_scheduler #(
        .tileDim(TILE),
        .screenWidth(WIDTH),
        .screenHeight(HEIGHT)
    ) dut (
        .BOARD_CLK(BOARD_CLK),
        .Reset(Reset),
        .renderStart(renderStart),
        .renderX(renderX),
        .renderY(renderY),
        .renderTileID(renderTileID),
        .renderDone(renderDone),
        .streamTileTrigger(streamTileTrigger),
        .xOffset(xOffset),
        .yOffset(yOffset),
        .streamingTileID(streamingTileID),
        .nextStreamingTileID(nextStreamingTileID),
        .doneStreaming(doneStreaming),
        .VGA_VS(VGA_VS),
        .doubleBuffer(doubleBuffer),
        .frameDone(frameDone)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pushFrame();
        tileExp_t t;
        for (int k = 0; k < TILES; k++) begin
            t.x  = 10'((k % TILES_X) * TILE);
            t.y  = 10'((k / TILES_X) * TILE);
            t.id = k[0];
            renderQ.push_back(t);
            streamQ.push_back(t);
        end
    endtask

    task automatic pulseDone();
        tbDone = 1'b1;
        @(negedge BOARD_CLK);
        tbDone = 1'b0;
    endtask

    task automatic waitStart(input string tag);
        int n = 0;
        do begin
            @(negedge BOARD_CLK);
            n++;
        end while (!renderStart && n < 200);
        checkOutput(tag, 64'(renderStart), 64'(1));
    endtask

    task automatic waitFrame(input string tag);
        int n = 0;
        do begin
            @(negedge BOARD_CLK);
            n++;
        end while (!frameDone && n < 3000);
        checkOutput(tag, 64'(frameDone), 64'(1));
    endtask

    task automatic waitFlip(input string tag);
        int n = 0;
        do begin
            @(negedge BOARD_CLK);
            n++;
        end while (!doubleBuffer && n < 20);
        checkOutput(tag, 64'(doubleBuffer), 64'(1));
    endtask

    always begin
        @(posedge BOARD_CLK);
        cycle++;
    end

    // Rasteriser: completes each requested tile three cycles after renderStart.
    always begin
        @(negedge BOARD_CLK);
        if (rastEnable && renderStart) begin
            repeat (2) @(negedge BOARD_CLK);
            rastDone = 1'b1;
            @(negedge BOARD_CLK);
            rastDone = 1'b0;
        end
    end

    // Framebuffer: goes busy two cycles after the trigger, idle FB_BUSY later.
    always begin
        @(negedge BOARD_CLK);
        if (!fbManual && streamTileTrigger) begin
            @(negedge BOARD_CLK);
            fbIdle = 1'b0;
            repeat (FB_BUSY) @(negedge BOARD_CLK);
            fbIdle = 1'b1;
            if (!sawRelease) begin
                sawRelease   = 1'b1;
                firstRelease = cycle + 1;
            end
        end
    end

    // Scoreboard consumer: pops expected tiles as the DUT issues them.
    always begin
        tileExp_t e;
        @(negedge BOARD_CLK);
        if (renderStart) begin
            renderStarts++;
            if (!sawRelease) startsBeforeRelease++;
            if (renderStarts == 3) thirdStart = cycle;
            if (renderQ.size() == 0) begin
                checkOutput("render_extra", 64'(renderStart), 64'(0));
            end else begin
                e = renderQ.pop_front();
                checkOutput("renderX", 64'(renderX), 64'(e.x));
                checkOutput("renderY", 64'(renderY), 64'(e.y));
                checkOutput("renderTileID", 64'(renderTileID), 64'(e.id));
            end
        end
        if (streamTileTrigger && !prevTrig) begin
            triggers++;
            if (streamQ.size() == 0) begin
                checkOutput("stream_extra", 64'(streamTileTrigger), 64'(0));
            end else begin
                e = streamQ.pop_front();
                checkOutput("xOffset", 64'(xOffset), 64'(e.x));
                checkOutput("yOffset", 64'(yOffset), 64'(e.y));
                checkOutput("streamingTileID", 64'(streamingTileID), 64'(e.id));
                checkOutput("nextStreamingTileID", 64'(nextStreamingTileID), 64'(e.id));
            end
        end
        if (streamTileTrigger) begin
            trigWidth++;
        end else begin
            if (prevTrig && !fbManual && !Reset) checkOutput("trig_width", 64'(trigWidth), 64'(2));
            trigWidth = 0;
        end
        prevTrig = streamTileTrigger;
        if (frameDone) frameDones++;
    end

    initial begin
        int markS;
        int markT;
        pushFrame();
        repeat (3) @(negedge BOARD_CLK);
        checkOutput("reset_outputs", 64'({renderStart, renderX, renderY, renderTileID, streamTileTrigger,
                    xOffset, yOffset, streamingTileID, nextStreamingTileID, doubleBuffer, frameDone}), 64'(0));
        Reset = 1'b0;
        @(negedge BOARD_CLK);
        checkOutput("first_start", 64'(renderStart), 64'(1));

        // Full frame with fast renders and slow streaming.
        waitFrame("frame1_done");
        checkOutput("starts_before_release", 64'(startsBeforeRelease), 64'(2));
        checkOutput("third_start_latency", 64'(thirdStart - firstRelease), 64'(1));
        markS = renderStarts;
        markT = triggers;
        repeat (20) @(negedge BOARD_CLK);
        checkOutput("idle_after_frame", 64'((renderStarts - markS) + (triggers - markT)), 64'(0));
        checkOutput("frame_done_once", 64'(frameDones), 64'(1));
        checkOutput("renderQ_drained", 64'(renderQ.size()), 64'(0));
        checkOutput("streamQ_drained", 64'(streamQ.size()), 64'(0));
        checkOutput("dbuf_before_vs", 64'(doubleBuffer), 64'(0));

        // Vertical sync flips the page and restarts at the origin.
        fbManual   = 1'b1;
        tbIdle     = 1'b1;
        rastEnable = 1'b0;
        pushFrame();
        VGA_VS = 1'b0;
        waitFlip("dbuf_flip");
        VGA_VS = 1'b1;
        waitStart("f2_start0");
        checkOutput("restart_origin", 64'({renderX, renderY}), 64'(0));

        pulseDone();
        waitStart("f2_start1");
        tbIdle = 1'b0;
        pulseDone();
        repeat (2) @(negedge BOARD_CLK);
        markS = renderStarts;
        pulseDone();
        repeat (3) @(negedge BOARD_CLK);
        checkOutput("spurious_done_ignored", 64'(renderStarts - markS), 64'(0));

        // Release of A, then renderDone into A coinciding with release of B.
        tbIdle = 1'b1;
        waitStart("f2_start2");
        tbIdle = 1'b0;
        @(negedge BOARD_CLK);
        tbDone = 1'b1;
        tbIdle = 1'b1;
        @(negedge BOARD_CLK);
        tbDone = 1'b0;
        @(negedge BOARD_CLK);
        checkOutput("simul_render_next", 64'(renderStart), 64'(1));
        checkOutput("simul_trigger_next", 64'(streamTileTrigger), 64'(1));

        // Reset while the framebuffer is mid-stream.
        tbIdle = 1'b0;
        pulseDone();
        @(negedge BOARD_CLK);
        checkOutput("in_run_before_reset", 64'(streamTileTrigger), 64'(0));
        Reset = 1'b1;
        renderQ.delete();
        streamQ.delete();
        pushFrame();
        rastEnable = 1'b1;
        @(negedge BOARD_CLK);
        checkOutput("mid_reset_outputs", 64'({renderStart, renderX, renderY, renderTileID, streamTileTrigger,
                    xOffset, yOffset, streamingTileID, nextStreamingTileID, doubleBuffer, frameDone}), 64'(0));
        Reset = 1'b0;
        markT = triggers;
        waitStart("post_reset_start");
        repeat (20) @(negedge BOARD_CLK);
        checkOutput("no_trigger_while_busy", 64'(triggers - markT), 64'(0));
        fbManual = 1'b0;
        waitFrame("frame_after_reset");
        checkOutput("renderQ_drained2", 64'(renderQ.size()), 64'(0));
        checkOutput("streamQ_drained2", 64'(streamQ.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
